multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore-FSM controller for the 8-bit multicycle CPU datapath.
- Consumes the datapath status buses: DI (5 b), IR opcode nibble (4 b), CZN flags (3 b).
- Drives every datapath load, write, mux-select and ALU-control line, sequencing fetch, decode, execute and writeback over 2-5 cycles per instruction.

Parameters:
- OP_ADD, 2'b00, aluOpControl code for a+b(+C when CC=1)
- OP_SUB, 2'b01, aluOpControl code for a-b
- OP_AND, 2'b10, aluOpControl code for a&b
- OP_NOT, 2'b11, aluOpControl code for ~a (a = aluIn1, the B-register path)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- DiToCU  in  5  DI register contents
- IrToCU  in  4  IR[7:4]
- CznToCU  in  3  flags: [0]=C, [1]=Z, [2]=N
- pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn  out  1 each  PC/DI/IR/TR controls
- aRegWriteEn, bRegWriteEn, aluResWriteEn, ldCZN  out  1 each  operand, result and flag loads
- accumulatorWriteEn, memoryWriteEn  out  1 each  write strobes
- PcOrTR  out  1  memory address select: 0=TR, 1=PC
- regOrMem  out  1  B-register input select: 0=memory, 1=accumulator
- RegBOr0, RegAOr0  out  1 each  1 forces the corresponding ALU input to zero
- accAddressSel  out  2  00=DI[4:3], 01=IR[3:2], 10=IR[1:0]
- aluOpControl  out  2  ALU operation
- CC  out  1  carry-in enable

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high: when rst=1 at a rising edge, the state becomes FETCH.
- Output decode: all outputs are decoded combinationally from the state register and are forced to 0 while rst=1. Every output not listed as asserted for a state is 0 in that state.
- Instruction format, memory type (IR[7]=0):
  - IR[6:5]: 00 LDA, 01 STA, 10 JMP, 11 JZ.
  - 13-bit address = {IR[4:0], byte2}.
  - Operand accumulator = DI[4:3].
- Instruction format, register type (IR[7]=1):
  - IR[6:4]: 000 ADD, 001 ADDC, 010 SUB, 011 AND, 100 NOT, 101 MOV, 110 NOP, 111 HLT.
  - Destination and first source = ACC[IR[3:2]]; second source = ACC[IR[1:0]].
- State assertions (memory reads are combinational on address):
  - FETCH: PcOrTR=1, irWriteEn=1, pcInc=1 -> DECODE.
  - DECODE, memory type: PcOrTR=1, trWriteEn=1, pcInc=1, diLoadEn=1.
    - LDA -> LD_RD; STA -> ST_A; JMP -> JUMP.
    - JZ -> JUMP if CznToCU[1]=1, else FETCH.
  - DECODE, register type: accAddressSel=01, aRegWriteEn=1, diLoadEn=1.
    - NOP -> FETCH; HLT -> HALT; all others -> RD_B.
  - RD_B: accAddressSel=10, regOrMem=1, bRegWriteEn=1 -> EXEC.
  - EXEC: aluResWriteEn=1, ldCZN=1 -> WB.
    - ADD: OP_ADD, CC=0. ADDC: OP_ADD, CC=1. SUB: OP_SUB. AND: OP_AND.
    - NOT: OP_NOT (result = ~ACC[IR[1:0]]).
    - MOV: OP_ADD, RegAOr0=1 (result = ACC[IR[1:0]]).
  - WB: accAddressSel=01, accumulatorWriteEn=1 -> FETCH.
  - LD_RD: PcOrTR=0, regOrMem=0, bRegWriteEn=1 -> LD_EX.
  - LD_EX: OP_ADD, RegAOr0=1, aluResWriteEn=1 -> LD_WB.
  - LD_WB: accAddressSel=00, accumulatorWriteEn=1 -> FETCH.
  - ST_A: accAddressSel=00, aRegWriteEn=1 -> ST_EX.
  - ST_EX: OP_ADD, RegBOr0=1, aluResWriteEn=1 -> ST_WR.
  - ST_WR: PcOrTR=0, memoryWriteEn=1 -> FETCH.
  - JUMP: pcLoadEn=1 -> FETCH.
  - HALT: all outputs 0; the state is held until rst.
- Cycle counts, FETCH to next FETCH:
  - Register ALU op: 5. LDA: 5. STA: 5.
  - JMP and JZ taken: 3. JZ not taken, NOP: 2.
- Exclusivity: pcInc and pcLoadEn are never both 1. memoryWriteEn and accumulatorWriteEn are never both 1.
- Reset mid-instruction: the instruction is abandoned. No write strobe asserts in the reset cycle. The next state is FETCH.
- Illegal states (unencoded state values) -> FETCH.
- Flags are updated only in EXEC (and in LD_EX when the optional feature is enabled).

Optional Feature:
- Macro: CU_LOAD_FLAGS_EN.
- Defined: LD_EX additionally asserts ldCZN=1, so LDA updates Z and N from the loaded byte. C is also written, and equals 0 because the operation is x+0 with CC=0.
- Undefined: LDA leaves CZN unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles in any state -> all outputs 0; the first cycle after release has PcOrTR=1, irWriteEn=1, pcInc=1.
- ADD, IrToCU=4'b1000, IR[3:0]=0110:
  - Expected output sequence over 5 cycles: FETCH, DECODE (accAddressSel=01, aRegWriteEn), RD_B (sel=10, bRegWriteEn), EXEC (OP_ADD, CC=0, ldCZN), WB (accumulatorWriteEn), then FETCH.
- LDA, IrToCU=4'b0001, DiToCU=5'b10xxx:
  - Expected: LD_RD with PcOrTR=0, bRegWriteEn=1.
  - LD_WB with accAddressSel=00 and accumulatorWriteEn=1.
  - ldCZN=0 throughout, or 1 in LD_EX when CU_LOAD_FLAGS_EN is defined.
- JZ, IrToCU=4'b0110:
  - CznToCU=3'b010 -> JUMP with pcLoadEn=1 (3 cycles total).
  - CznToCU=3'b000 -> FETCH directly after DECODE, and pcLoadEn is never 1.
- STA then HLT:
  - STA: ST_WR asserts memoryWriteEn=1 with PcOrTR=0.
  - HLT (IrToCU=4'b1111): all outputs 0 for 10+ cycles; rst=1 -> FETCH.
- Reset mid-instruction: rst asserted during EXEC of ADDC -> no accumulatorWriteEn pulse; the first cycle after release is FETCH.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Moore-FSM controller for the 8-bit multicycle CPU datapath.
// Optional: define CU_LOAD_FLAGS_EN so LDA also loads CZN in LD_EX.
module multicycle_control_unit #(
  parameter logic [1:0] OP_ADD = 2'b00,
  parameter logic [1:0] OP_SUB = 2'b01,
  parameter logic [1:0] OP_AND = 2'b10,
  parameter logic [1:0] OP_NOT = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] DiToCU,
  input  logic [3:0] IrToCU,
  input  logic [2:0] CznToCU,
  output logic       pcInc,
  output logic       pcLoadEn,
  output logic       diLoadEn,
  output logic       irWriteEn,
  output logic       trWriteEn,
  output logic       aRegWriteEn,
  output logic       bRegWriteEn,
  output logic       aluResWriteEn,
  output logic       ldCZN,
  output logic       accumulatorWriteEn,
  output logic       memoryWriteEn,
  output logic       PcOrTR,
  output logic       regOrMem,
  output logic       RegBOr0,
  output logic       RegAOr0,
  output logic [1:0] accAddressSel,
  output logic [1:0] aluOpControl,
  output logic       CC
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    RD_B   = 4'd2,
    EXEC   = 4'd3,
    WB     = 4'd4,
    LD_RD  = 4'd5,
    LD_EX  = 4'd6,
    LD_WB  = 4'd7,
    ST_A   = 4'd8,
    ST_EX  = 4'd9,
    ST_WR  = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcInc;
    logic       pcLoadEn;
    logic       diLoadEn;
    logic       irWriteEn;
    logic       trWriteEn;
    logic       aRegWriteEn;
    logic       bRegWriteEn;
    logic       aluResWriteEn;
    logic       ldCZN;
    logic       accumulatorWriteEn;
    logic       memoryWriteEn;
    logic       PcOrTR;
    logic       regOrMem;
    logic       RegBOr0;
    logic       RegAOr0;
    logic [1:0] accAddressSel;
    logic [1:0] aluOpControl;
    logic       CC;
  } ctl_t;

  state_t state, nextState;
  ctl_t   ctl, ctlOut;

  logic       memType;
  logic [1:0] memOp;
  logic [2:0] regOp;
  logic       zFlag;
  logic       unusedInputs;

  assign memType = ~IrToCU[3];
  assign memOp   = IrToCU[2:1];
  assign regOp   = IrToCU[2:0];
  assign zFlag   = CznToCU[1];

  // DI contents and C/N only steer the datapath, never the sequencing
  assign unusedInputs = ^{DiToCU, CznToCU[2], CznToCU[0]};

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= nextState;
  end

  always_comb begin
    ctl       = '0;
    nextState = FETCH;
    case (state)
      FETCH: begin
        ctl.PcOrTR    = 1'b1;
        ctl.irWriteEn = 1'b1;
        ctl.pcInc     = 1'b1;
        nextState     = DECODE;
      end
      DECODE: begin
        if (memType) begin
          ctl.PcOrTR    = 1'b1;
          ctl.trWriteEn = 1'b1;
          ctl.pcInc     = 1'b1;
          ctl.diLoadEn  = 1'b1;
          case (memOp)
            2'b00:   nextState = LD_RD;
            2'b01:   nextState = ST_A;
            2'b10:   nextState = JUMP;
            default: nextState = zFlag ? JUMP : FETCH;
          endcase
        end else begin
          ctl.accAddressSel = 2'b01;
          ctl.aRegWriteEn   = 1'b1;
          ctl.diLoadEn      = 1'b1;
          case (regOp)
            3'b110:  nextState = FETCH;
            3'b111:  nextState = HALT;
            default: nextState = RD_B;
          endcase
        end
      end
      RD_B: begin
        ctl.accAddressSel = 2'b10;
        ctl.regOrMem      = 1'b1;
        ctl.bRegWriteEn   = 1'b1;
        nextState         = EXEC;
      end
      EXEC: begin
        ctl.aluResWriteEn = 1'b1;
        ctl.ldCZN         = 1'b1;
        ctl.aluOpControl  = OP_ADD;
        case (regOp)
          3'b001: ctl.CC = 1'b1;
          3'b010: ctl.aluOpControl = OP_SUB;
          3'b011: ctl.aluOpControl = OP_AND;
          3'b100: ctl.aluOpControl = OP_NOT;
          3'b101: ctl.RegAOr0 = 1'b1;
          default: ;
        endcase
        nextState = WB;
      end
      WB: begin
        ctl.accAddressSel      = 2'b01;
        ctl.accumulatorWriteEn = 1'b1;
        nextState              = FETCH;
      end
      LD_RD: begin
        ctl.bRegWriteEn = 1'b1;
        nextState       = LD_EX;
      end
      LD_EX: begin
        ctl.aluOpControl  = OP_ADD;
        ctl.RegAOr0       = 1'b1;
        ctl.aluResWriteEn = 1'b1;
`ifdef CU_LOAD_FLAGS_EN
        ctl.ldCZN         = 1'b1;
`else
        ctl.ldCZN         = 1'b0;
`endif
        nextState         = LD_WB;
      end
      LD_WB: begin
        ctl.accumulatorWriteEn = 1'b1;
        nextState              = FETCH;
      end
      ST_A: begin
        ctl.aRegWriteEn = 1'b1;
        nextState       = ST_EX;
      end
      ST_EX: begin
        ctl.aluOpControl  = OP_ADD;
        ctl.RegBOr0       = 1'b1;
        ctl.aluResWriteEn = 1'b1;
        nextState         = ST_WR;
      end
      ST_WR: begin
        ctl.memoryWriteEn = 1'b1;
        nextState         = FETCH;
      end
      JUMP: begin
        ctl.pcLoadEn = 1'b1;
        nextState    = FETCH;
      end
      HALT: nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  assign ctlOut = rst ? '0 : ctl;

  assign pcInc              = ctlOut.pcInc;
  assign pcLoadEn           = ctlOut.pcLoadEn;
  assign diLoadEn           = ctlOut.diLoadEn;
  assign irWriteEn          = ctlOut.irWriteEn;
  assign trWriteEn          = ctlOut.trWriteEn;
  assign aRegWriteEn        = ctlOut.aRegWriteEn;
  assign bRegWriteEn        = ctlOut.bRegWriteEn;
  assign aluResWriteEn      = ctlOut.aluResWriteEn;
  assign ldCZN              = ctlOut.ldCZN;
  assign accumulatorWriteEn = ctlOut.accumulatorWriteEn;
  assign memoryWriteEn      = ctlOut.memoryWriteEn;
  assign PcOrTR             = ctlOut.PcOrTR;
  assign regOrMem           = ctlOut.regOrMem;
  assign RegBOr0            = ctlOut.RegBOr0;
  assign RegAOr0            = ctlOut.RegAOr0;
  assign accAddressSel      = ctlOut.accAddressSel;
  assign aluOpControl       = ctlOut.aluOpControl;
  assign CC                 = ctlOut.CC;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Vector/scoreboard bench for multicycle_control_unit.
// Output word order: pcInc..CC as listed in the port list.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] DiToCU = '0;
  logic [3:0] IrToCU = '0;
  logic [2:0] CznToCU = '0;
  logic pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn;
  logic aRegWriteEn, bRegWriteEn, aluResWriteEn, ldCZN;
  logic accumulatorWriteEn, memoryWriteEn;
  logic PcOrTR, regOrMem, RegBOr0, RegAOr0, CC;
  logic [1:0] accAddressSel, aluOpControl;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst),
    .DiToCU(DiToCU), .IrToCU(IrToCU), .CznToCU(CznToCU),
    .pcInc(pcInc), .pcLoadEn(pcLoadEn), .diLoadEn(diLoadEn),
    .irWriteEn(irWriteEn), .trWriteEn(trWriteEn),
    .aRegWriteEn(aRegWriteEn), .bRegWriteEn(bRegWriteEn),
    .aluResWriteEn(aluResWriteEn), .ldCZN(ldCZN),
    .accumulatorWriteEn(accumulatorWriteEn),
    .memoryWriteEn(memoryWriteEn),
    .PcOrTR(PcOrTR), .regOrMem(regOrMem),
    .RegBOr0(RegBOr0), .RegAOr0(RegAOr0),
    .accAddressSel(accAddressSel),
    .aluOpControl(aluOpControl), .CC(CC)
  );

  always #5 clk = ~clk;

  logic [19:0] act;
  assign act = {pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn,
                aRegWriteEn, bRegWriteEn, aluResWriteEn, ldCZN,
                accumulatorWriteEn, memoryWriteEn,
                PcOrTR, regOrMem, RegBOr0, RegAOr0,
                accAddressSel, aluOpControl, CC};

  localparam logic [19:0] PCINC = 20'd1 << 19;
  localparam logic [19:0] PCLD  = 20'd1 << 18;
  localparam logic [19:0] DILD  = 20'd1 << 17;
  localparam logic [19:0] IRWE  = 20'd1 << 16;
  localparam logic [19:0] TRWE  = 20'd1 << 15;
  localparam logic [19:0] AWE   = 20'd1 << 14;
  localparam logic [19:0] BWE   = 20'd1 << 13;
  localparam logic [19:0] ALUWE = 20'd1 << 12;
  localparam logic [19:0] LDF   = 20'd1 << 11;
  localparam logic [19:0] ACCWE = 20'd1 << 10;
  localparam logic [19:0] MEMWE = 20'd1 << 9;
  localparam logic [19:0] PCOR  = 20'd1 << 8;
  localparam logic [19:0] ROM   = 20'd1 << 7;
  localparam logic [19:0] RB0   = 20'd1 << 6;
  localparam logic [19:0] RA0   = 20'd1 << 5;
  localparam logic [19:0] S01   = 20'd1 << 3;
  localparam logic [19:0] S10   = 20'd2 << 3;
  localparam logic [19:0] OSUB  = 20'd1 << 1;
  localparam logic [19:0] OAND  = 20'd2 << 1;
  localparam logic [19:0] ONOT  = 20'd3 << 1;
  localparam logic [19:0] CCB   = 20'd1;

  localparam logic [19:0] E_FETCH = PCINC | PCOR | IRWE;
  localparam logic [19:0] E_DECM  = PCOR | TRWE | PCINC | DILD;
  localparam logic [19:0] E_DECR  = S01 | AWE | DILD;
  localparam logic [19:0] E_RDB   = S10 | ROM | BWE;
  localparam logic [19:0] E_EX    = ALUWE | LDF;
  localparam logic [19:0] E_WB    = S01 | ACCWE;
  localparam logic [19:0] E_LDRD  = BWE;
`ifdef CU_LOAD_FLAGS_EN
  localparam logic [19:0] E_LDEX  = RA0 | ALUWE | LDF;
`else
  localparam logic [19:0] E_LDEX  = RA0 | ALUWE;
`endif
  localparam logic [19:0] E_LDWB  = ACCWE;
  localparam logic [19:0] E_STA   = AWE;
  localparam logic [19:0] E_STEX  = RB0 | ALUWE;
  localparam logic [19:0] E_STWR  = MEMWE;
  localparam logic [19:0] E_JUMP  = PCLD;
  localparam logic [19:0] E_ZERO  = '0;

  typedef struct {
    logic        r;
    logic [3:0]  ir;
    logic [2:0]  czn;
    logic [19:0] exp;
    string       tag;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] sb[$];
  int          nCmp = 0;
  int          nBad = 0;

  task automatic add(input logic r, input logic [3:0] ir,
                     input logic [2:0] czn, input logic [19:0] e,
                     input string t);
    vec_t v;
    v.r = r; v.ir = ir; v.czn = czn; v.exp = e; v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic addReg(input logic [3:0] ir, input logic [19:0] ex,
                        input string t);
    add(1'b0, ir, 3'b000, E_FETCH, {t, ".fetch"});
    add(1'b0, ir, 3'b000, E_DECR,  {t, ".decode"});
    add(1'b0, ir, 3'b000, E_RDB,   {t, ".rdb"});
    add(1'b0, ir, 3'b000, ex,      {t, ".exec"});
    add(1'b0, ir, 3'b000, E_WB,    {t, ".wb"});
  endtask

  task automatic check(input string t);
    logic [19:0] e;
    e = sb.pop_front();
    nCmp++;
    if (act !== e) begin
      nBad++;
      $display("FAIL %s: got %05h expected %05h", t, act, e);
    end
    nCmp++;
    if ((pcInc && pcLoadEn) || (memoryWriteEn && accumulatorWriteEn)) begin
      nBad++;
      $display("FAIL %s.excl: got %05h expected exclusive strobes", t, act);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    rst     = v.r;
    IrToCU  = v.ir;
    CznToCU = v.czn;
    DiToCU  = 5'(10'b10011 + $urandom_range(0, 7) - 3);
    sb.push_back(v.exp);
    #2;
    check(v.tag);
  endtask

  task automatic one(input logic r, input logic [3:0] ir,
                     input logic [19:0] e, input string t);
    vec_t v;
    v.r = r; v.ir = ir; v.czn = 3'b000; v.exp = e; v.tag = t;
    step(v);
  endtask

  initial begin
    add(1'b1, 4'b1000, 3'b000, E_ZERO, "rst0");
    add(1'b1, 4'b1000, 3'b000, E_ZERO, "rst1");
    addReg(4'b1000, E_EX,        "add");
    addReg(4'b1001, E_EX | CCB,  "addc");
    addReg(4'b1010, E_EX | OSUB, "sub");
    addReg(4'b1011, E_EX | OAND, "and");
    addReg(4'b1100, E_EX | ONOT, "not");
    addReg(4'b1101, E_EX | RA0,  "mov");
    add(1'b0, 4'b1110, 3'b000, E_FETCH, "nop.fetch");
    add(1'b0, 4'b1110, 3'b000, E_DECR,  "nop.decode");
    add(1'b0, 4'b0001, 3'b000, E_FETCH, "lda.fetch");
    add(1'b0, 4'b0001, 3'b000, E_DECM,  "lda.decode");
    add(1'b0, 4'b0001, 3'b000, E_LDRD,  "lda.rd");
    add(1'b0, 4'b0001, 3'b000, E_LDEX,  "lda.ex");
    add(1'b0, 4'b0001, 3'b000, E_LDWB,  "lda.wb");
    add(1'b0, 4'b0010, 3'b000, E_FETCH, "sta.fetch");
    add(1'b0, 4'b0010, 3'b000, E_DECM,  "sta.decode");
    add(1'b0, 4'b0010, 3'b000, E_STA,   "sta.a");
    add(1'b0, 4'b0010, 3'b000, E_STEX,  "sta.ex");
    add(1'b0, 4'b0010, 3'b000, E_STWR,  "sta.wr");
    add(1'b0, 4'b0100, 3'b000, E_FETCH, "jmp.fetch");
    add(1'b0, 4'b0100, 3'b000, E_DECM,  "jmp.decode");
    add(1'b0, 4'b0100, 3'b000, E_JUMP,  "jmp.jump");
    add(1'b0, 4'b0110, 3'b010, E_FETCH, "jzt.fetch");
    add(1'b0, 4'b0110, 3'b010, E_DECM,  "jzt.decode");
    add(1'b0, 4'b0110, 3'b010, E_JUMP,  "jzt.jump");
    add(1'b0, 4'b0110, 3'b000, E_FETCH, "jzn.fetch");
    add(1'b0, 4'b0110, 3'b000, E_DECM,  "jzn.decode");
    add(1'b0, 4'b0110, 3'b101, E_FETCH, "jzn2.fetch");
    add(1'b0, 4'b0110, 3'b101, E_DECM,  "jzn2.decode");
    add(1'b0, 4'b1000, 3'b000, E_FETCH, "post.fetch");
    add(1'b0, 4'b1000, 3'b000, E_DECR,  "post.decode");
    add(1'b0, 4'b1000, 3'b000, E_RDB,   "post.rdb");

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // abandon the in-flight ADD right after RD_B
    one(1'b1, 4'b1000, E_ZERO,  "rstmid.a");
    one(1'b0, 4'b1000, E_FETCH, "rstmid.a.fetch");

    one(1'b0, 4'b1001, E_DECR,  "rstmid.decode");
    one(1'b0, 4'b1001, E_RDB,   "rstmid.rdb");
    one(1'b1, 4'b1001, E_ZERO,  "rstmid.exec");
    one(1'b0, 4'b1001, E_FETCH, "rstmid.fetch");
    one(1'b0, 4'b1111, E_DECR,  "hlt.decode");
    for (int i = 0; i < 12; i++) one(1'b0, 4'b1111, E_ZERO, "hlt.hold");
    one(1'b1, 4'b1111, E_ZERO,  "hlt.rst");
    one(1'b0, 4'b1111, E_FETCH, "hlt.fetch");

    nCmp++;
    if (sb.size() != 0) begin
      nBad++;
      $display("FAIL sb.drain: got %0d expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
